// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg -- shared definitions for the program-counter run controller.
//
// Contents:
//    state_t              run-controller states (IDLE, CLEAR, RUN, DONE, ERROR)
//    DEFAULT_STACK_DEPTH  default number of return-address stack entries
//    CNT_W                width of the optional RUN-cycle counter
//
// Optional feature macro used by pc_sequencer: PC_SEQ_CYCLE_COUNT_EN.
package pc_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CLEAR = 3'd1,
      ST_RUN   = 3'd2,
      ST_DONE  = 3'd3,
      ST_ERROR = 3'd4
   } state_t;

   localparam int DEFAULT_STACK_DEPTH = 4;
   localparam int CNT_W               = 16;

endpackage : pc_seq_pkg

// File: rtl/ret_stack.sv
// ret_stack -- parameterised LIFO holding return addresses.
//
// Parameters:
//    D      entry width in bits
//    DEPTH  number of entries (power of two, >= 2)
//
// Ports:
//    clk       in   system clock
//    reset     in   asynchronous active-high reset (empties stack, zeroes entries)
//    clear_i   in   synchronous empty request (depth -> 0)
//    push_i    in   write data_i above the current top (ignored when full)
//    pop_i     in   remove the top entry (ignored when empty)
//    replace_i in   overwrite the top entry with data_i, depth unchanged
//    data_i    in   value to push / replace
//    top_o     out  top entry, 0 when empty
//    depth_o   out  number of valid entries (0..DEPTH)
//    full_o    out  depth == DEPTH
//    empty_o   out  depth == 0
//
// The caller decides which operations are legal; this block only refuses
// operations that would corrupt its own bookkeeping.
module ret_stack #(
   parameter int D     = 10,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       clear_i,
   input  logic                       push_i,
   input  logic                       pop_i,
   input  logic                       replace_i,
   input  logic [D-1:0]               data_i,
   output logic [D-1:0]               top_o,
   output logic [$clog2(DEPTH):0]     depth_o,
   output logic                       full_o,
   output logic                       empty_o
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]                depth_q, depth_d;
   logic [DEPTH-1:0][D-1:0]    entries;
   logic [AW-1:0]              top_idx;

   assign full_o  = (depth_q == (AW+1)'(DEPTH));
   assign empty_o = (depth_q == '0);
   assign depth_o = depth_q;

   // Index of the current top; only meaningful when not empty.
   assign top_idx = AW'(depth_q - 1'b1);
   assign top_o   = empty_o ? '0 : entries[top_idx];

   always_comb begin
      depth_d = depth_q;
      if (clear_i) begin
         depth_d = '0;
      end else if (push_i && !full_o) begin
         depth_d = depth_q + 1'b1;
      end else if (pop_i && !empty_o) begin
         depth_d = depth_q - 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         depth_q <= '0;
      end else begin
         depth_q <= depth_d;
      end
   end

   // One register per slot. A push writes the slot just above the top,
   // a replace rewrites the slot holding the top.
   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
         localparam logic [AW:0] SLOT_AT    = (AW+1)'(gi);
         localparam logic [AW:0] SLOT_ABOVE = (AW+1)'(gi + 1);
         logic [D-1:0] slot_q;

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               slot_q <= '0;
            end else if (!clear_i) begin
               if (push_i && depth_q == SLOT_AT) begin
                  slot_q <= data_i;
               end else if (replace_i && depth_q == SLOT_ABOVE) begin
                  slot_q <= data_i;
               end
            end
         end

         assign entries[gi] = slot_q;
      end
   endgenerate

endmodule : ret_stack

// File: rtl/pc_sequencer.sv
// pc_sequencer -- run controller for the program counter and owner of the
// hardware return-address stack.
//
// Parameters:
//    D            PC width in bits
//    STACK_DEPTH  return-address stack entries (power of two, >= 2)
//
// Ports:
//    clk             in   system clock
//    reset           in   asynchronous active-high reset
//    start           in   one-cycle pulse, begins or restarts a run
//    programCounter  in   current PC value
//    callEn          in   decoded call instruction
//    retEn           in   decoded return instruction
//    haltEn          in   decoded halt instruction
//    stallReq        in   current instruction not complete
//    pcClear         out  PC clear (high for the single CLEAR cycle)
//    pcHold          out  PC must keep its value this cycle
//    retTarget       out  top-of-stack return address (0 when empty)
//    retValid        out  return accepted, PC loads retTarget
//    running         out  state is RUN
//    done            out  run finished (normal or error)
//    stackErr        out  stack overflow/underflow ended this run
//    cycleCount      out  RUN cycles this run, saturating
//                         (present only with PC_SEQ_CYCLE_COUNT_EN)
//
// Build option: define PC_SEQ_CYCLE_COUNT_EN to add the cycleCount port
// and its counter.
module pc_sequencer
   import pc_seq_pkg::*;
#(
   parameter int D           = 10,
   parameter int STACK_DEPTH = DEFAULT_STACK_DEPTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [D-1:0]     programCounter,
   input  logic             callEn,
   input  logic             retEn,
   input  logic             haltEn,
   input  logic             stallReq,
   output logic             pcClear,
   output logic             pcHold,
   output logic [D-1:0]     retTarget,
   output logic             retValid,
   output logic             running,
   output logic             done,
`ifdef PC_SEQ_CYCLE_COUNT_EN
   output logic             stackErr,
   output logic [CNT_W-1:0] cycleCount
`else
   output logic             stackErr
`endif
);

   localparam int AW = $clog2(STACK_DEPTH);

   state_t state_q, state_d;

   logic [D-1:0] stack_top;
   logic [AW:0]  stack_depth;
   logic         stack_full;
   logic         stack_empty;
   logic [D-1:0] push_data;

   logic in_run;
   logic accept;
   logic call_acc;
   logic ret_acc;
   logic has_entry;
   logic underflow;
   logic overflow;
   logic do_push;
   logic do_pop;
   logic do_replace;
   logic stack_clear;

   // An instruction is only acted on in RUN when it is complete and no
   // restart or halt takes priority over it.
   assign in_run    = (state_q == ST_RUN);
   assign accept    = in_run & ~stallReq & ~start & ~haltEn;
   assign call_acc  = accept & callEn;
   assign ret_acc   = accept & retEn;
   assign has_entry = (stack_depth != '0);

   // A return with nothing to return to is an error even when paired with
   // a call; a lone call into a full stack is an error. A call+return pair
   // on a full stack is fine because it only replaces the top.
   assign underflow  = ret_acc & stack_empty;
   assign overflow   = call_acc & ~retEn & stack_full;
   assign do_push    = call_acc & ~retEn & ~stack_full;
   assign do_pop     = ret_acc & ~callEn & has_entry;
   assign do_replace = call_acc & retEn & has_entry;

   assign push_data   = programCounter + D'(1);
   assign stack_clear = (state_q == ST_CLEAR);

   ret_stack #(
      .D     (D),
      .DEPTH (STACK_DEPTH)
   ) u_ret_stack (
      .clk       (clk),
      .reset     (reset),
      .clear_i   (stack_clear),
      .push_i    (do_push),
      .pop_i     (do_pop),
      .replace_i (do_replace),
      .data_i    (push_data),
      .top_o     (stack_top),
      .depth_o   (stack_depth),
      .full_o    (stack_full),
      .empty_o   (stack_empty)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (start) state_d = ST_CLEAR;
         end
         ST_CLEAR: begin
            state_d = ST_RUN;
         end
         ST_RUN: begin
            if (start) begin
               state_d = ST_CLEAR;
            end else if (!stallReq) begin
               if (haltEn) begin
                  state_d = ST_DONE;
               end else if (underflow || overflow) begin
                  state_d = ST_ERROR;
               end
            end
         end
         ST_DONE, ST_ERROR: begin
            if (start) state_d = ST_CLEAR;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign pcClear   = (state_q == ST_CLEAR);
   assign running   = in_run;
   assign done      = (state_q == ST_DONE) || (state_q == ST_ERROR);
   // The error flag lives in the state itself: it is set on entering ERROR
   // and cleared by the CLEAR state of the next run.
   assign stackErr  = (state_q == ST_ERROR);
   assign pcHold    = in_run ? stallReq : 1'b1;
   assign retValid  = ret_acc & has_entry;
   assign retTarget = stack_top;

`ifdef PC_SEQ_CYCLE_COUNT_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Counts every RUN cycle, stalls included, and sticks at all-ones.
   always_comb begin
      cnt_d = cnt_q;
      if (state_q == ST_CLEAR) begin
         cnt_d = '0;
      end else if (in_run && cnt_q != '1) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cycleCount = cnt_q;
`endif

endmodule : pc_sequencer

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer -- self-checking bench for pc_sequencer.
// A reference model predicts the outputs of each cycle; the prediction is
// queued when the stimulus is driven and compared when the DUT output is
// sampled mid-cycle. Build with PC_SEQ_CYCLE_COUNT_EN to also check cycleCount.
module tb_pc_sequencer;

   localparam int D  = 10;
   localparam int SD = 4;

   localparam int M_IDLE  = 0;
   localparam int M_CLEAR = 1;
   localparam int M_RUN   = 2;
   localparam int M_DONE  = 3;
   localparam int M_ERROR = 4;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic [D-1:0] programCounter;
   logic         callEn;
   logic         retEn;
   logic         haltEn;
   logic         stallReq;
   logic         pcClear;
   logic         pcHold;
   logic [D-1:0] retTarget;
   logic         retValid;
   logic         running;
   logic         done;
   logic         stackErr;
`ifdef PC_SEQ_CYCLE_COUNT_EN
   logic [15:0]  cycleCount;
`endif

   pc_sequencer #(.D(D), .STACK_DEPTH(SD)) dut (
      .clk            (clk),
      .reset          (reset),
      .start          (start),
      .programCounter (programCounter),
      .callEn         (callEn),
      .retEn          (retEn),
      .haltEn         (haltEn),
      .stallReq       (stallReq),
      .pcClear        (pcClear),
      .pcHold         (pcHold),
      .retTarget      (retTarget),
      .retValid       (retValid),
      .running        (running),
`ifdef PC_SEQ_CYCLE_COUNT_EN
      .done           (done),
      .stackErr       (stackErr),
      .cycleCount     (cycleCount)
`else
      .done           (done),
      .stackErr       (stackErr)
`endif
   );

   always #5 clk = ~clk;

   int vec_cnt  = 0;
   int miss_cnt = 0;
   int txn_cnt  = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         miss_cnt++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   int           m_state;
   logic [D-1:0] m_stk[$];
   int           m_cnt;

   typedef struct {
      logic         pc_clear;
      logic         pc_hold;
      logic         ret_valid;
      logic         run;
      logic         fin;
      logic         err;
      logic [D-1:0] target;
      int           cnt;
   } exp_t;

   exp_t sb_q[$];

   function automatic void model_reset();
      m_state = M_IDLE;
      m_stk.delete();
      m_cnt = 0;
   endfunction

   function automatic void model_step(input logic s, input logic c, input logic r,
                                      input logic h, input logic st, input logic [D-1:0] pc);
      logic [D-1:0] ret_addr;
      ret_addr = pc + 1'b1;
      case (m_state)
         M_IDLE:  if (s) m_state = M_CLEAR;
         M_CLEAR: begin
            m_stk.delete();
            m_cnt   = 0;
            m_state = M_RUN;
         end
         M_RUN: begin
            if (m_cnt < 65535) m_cnt++;
            if (s) m_state = M_CLEAR;
            else if (!st) begin
               if (h) m_state = M_DONE;
               else if (r) begin
                  if (m_stk.size() == 0) m_state = M_ERROR;
                  else if (c) m_stk[m_stk.size()-1] = ret_addr;
                  else void'(m_stk.pop_back());
               end else if (c) begin
                  if (m_stk.size() == SD) m_state = M_ERROR;
                  else m_stk.push_back(ret_addr);
               end
            end
         end
         default: if (s) m_state = M_CLEAR;
      endcase
   endfunction

   // One clock cycle: drive inputs, queue the prediction, sample the DUT
   // mid-cycle, then advance the model at the active edge.
   task automatic cyc(input string tag, input logic s, input logic c, input logic r,
                      input logic h, input logic st, input logic [D-1:0] pc);
      exp_t e;
      exp_t g;
      int   dep;
      @(negedge clk);
      start = s; callEn = c; retEn = r; haltEn = h; stallReq = st; programCounter = pc;
      dep         = m_stk.size();
      e.pc_clear  = (m_state == M_CLEAR);
      e.run       = (m_state == M_RUN);
      e.pc_hold   = (m_state == M_RUN) ? st : 1'b1;
      e.fin       = (m_state == M_DONE) || (m_state == M_ERROR);
      e.err       = (m_state == M_ERROR);
      e.target    = (dep > 0) ? m_stk[dep-1] : '0;
      e.ret_valid = (m_state == M_RUN) && !st && !s && !h && r && (dep > 0);
      e.cnt       = m_cnt;
      sb_q.push_back(e);
      #2;
      g = sb_q.pop_front();
      chk({tag, ".pcClear"},   pcClear,   g.pc_clear);
      chk({tag, ".pcHold"},    pcHold,    g.pc_hold);
      chk({tag, ".retValid"},  retValid,  g.ret_valid);
      chk({tag, ".running"},   running,   g.run);
      chk({tag, ".done"},      done,      g.fin);
      chk({tag, ".stackErr"},  stackErr,  g.err);
      chk({tag, ".retTarget"}, retTarget, g.target);
`ifdef PC_SEQ_CYCLE_COUNT_EN
      chk({tag, ".cycleCount"}, cycleCount, g.cnt);
`endif
      txn_cnt++;
      $display("txn %0d %s: s=%b c=%b r=%b h=%b st=%b pc=%0d -> hold=%b rv=%b tgt=%0d run=%b done=%b err=%b",
               txn_cnt, tag, s, c, r, h, st, pc, pcHold, retValid, retTarget, running, done, stackErr);
      @(posedge clk);
      model_step(s, c, r, h, st, pc);
   endtask

   // Asynchronous reset asserted between clock edges; outputs must react at once.
   task automatic do_reset(input string tag);
      @(negedge clk);
      start = 0; callEn = 0; retEn = 0; haltEn = 0; stallReq = 0; programCounter = '0;
      #2;
      reset = 1'b1;
      #1;
      model_reset();
      chk({tag, ".pcHold"},    pcHold,    1'b1);
      chk({tag, ".pcClear"},   pcClear,   1'b0);
      chk({tag, ".running"},   running,   1'b0);
      chk({tag, ".done"},      done,      1'b0);
      chk({tag, ".stackErr"},  stackErr,  1'b0);
      chk({tag, ".retValid"},  retValid,  1'b0);
      chk({tag, ".retTarget"}, retTarget, 0);
`ifdef PC_SEQ_CYCLE_COUNT_EN
      chk({tag, ".cycleCount"}, cycleCount, 0);
`endif
      @(negedge clk);
      reset = 1'b0;
   endtask

   // Start a run from any state: start pulse, then the CLEAR cycle.
   task automatic begin_run(input string tag);
      cyc({tag, "_start"}, 1, 0, 0, 0, 0, '0);
      cyc({tag, "_clear"}, 0, 0, 0, 0, 0, '0);
   endtask

   initial begin
      reset = 1'b1;
      start = 0; callEn = 0; retEn = 0; haltEn = 0; stallReq = 0; programCounter = '0;
      model_reset();
      do_reset("rst0");
      cyc("idle", 0, 0, 0, 0, 0, 10'd3);

      // Nested call/return
      begin_run("nest");
      cyc("call5",  0, 1, 0, 0, 0, 10'd5);
      cyc("call20", 0, 1, 0, 0, 0, 10'd20);
      #2 chk("nest.top21", retTarget, 21);
      cyc("ret1",   0, 0, 1, 0, 0, 10'd40);
      cyc("ret2",   0, 0, 1, 0, 0, 10'd22);
      cyc("empty",  0, 0, 0, 0, 0, 10'd7);

      // Overflow on the fifth call
      begin_run("ovf");
      for (int i = 0; i < 5; i++) cyc("ovf_call", 0, 1, 0, 0, 0, 10'(100 + i));
      #2;
      chk("ovf.top104", retTarget, 104);
      chk("ovf.err",    stackErr,  1'b1);
      cyc("ovf_err", 0, 0, 0, 0, 0, '0);
      begin_run("ovf_rst");
      cyc("ovf_clr", 0, 0, 0, 0, 0, '0);

      // Underflow
      cyc("und_ret", 0, 0, 1, 0, 0, 10'd9);
      cyc("und_err", 0, 0, 0, 0, 0, '0);

      // Call+return together
      begin_run("cr");
      cyc("cr_call5", 0, 1, 0, 0, 0, 10'd5);
      cyc("cr_both",  0, 1, 1, 0, 0, 10'd30);
      #2 chk("cr.top31", retTarget, 31);
      cyc("cr_ret",   0, 0, 1, 0, 0, 10'd31);
      cyc("cr_empty", 0, 0, 0, 0, 0, '0);

      // Stall with call/halt held, then halt accepted
      begin_run("stl");
      cyc("stl_run", 0, 0, 0, 0, 0, 10'd0);
      for (int i = 0; i < 3; i++) cyc("stl_hold", 0, 1, 0, 1, 1, 10'd1);
      cyc("stl_halt", 0, 1, 0, 1, 0, 10'd1);
      cyc("stl_done", 0, 0, 0, 0, 0, '0);
`ifdef PC_SEQ_CYCLE_COUNT_EN
      #2 chk("stl.count5", cycleCount, 5);
`endif

      // PC wrap and restart priority
      begin_run("wrap");
      cyc("wrap_call", 0, 1, 0, 0, 0, 10'd1023);
      #2 chk("wrap.top0", retTarget, 0);
      cyc("wrap_ret",  0, 0, 1, 0, 0, 10'd2);
      cyc("wrap_call2", 0, 1, 0, 0, 0, 10'd60);
      cyc("rs_start", 1, 1, 0, 1, 0, 10'd61);
      cyc("rs_clear", 0, 0, 0, 0, 0, '0);
      cyc("rs_ret",   0, 0, 1, 0, 0, 10'd3);

      // Reset in the middle of a run with two entries
      begin_run("mid");
      cyc("mid_c1", 0, 1, 0, 0, 0, 10'd7);
      cyc("mid_c2", 0, 1, 0, 0, 0, 10'd8);
      do_reset("midrst");
      cyc("mid_idle", 0, 0, 0, 0, 0, '0);
      begin_run("mid2");
      cyc("mid_run", 0, 0, 0, 0, 0, '0);

      // Random traffic
      for (int i = 0; i < 300; i++) begin
         cyc("rnd", ($urandom_range(0, 19) == 0), ($urandom_range(0, 2) == 0),
             ($urandom_range(0, 2) == 0), ($urandom_range(0, 15) == 0),
             ($urandom_range(0, 3) == 0), 10'($urandom_range(0, 1023)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
      $finish;
   end

endmodule : tb_pc_sequencer
